game_tick_scheduler: RTL and testbench
======================================

# game_tick_scheduler

Central time-base and game-timer controller for the Minesweeper board. One cascaded prescaler on the 50 MHz board clock produces single-cycle enable ticks at 10 kHz, 1 kHz, 100 Hz and 1 Hz; the rest of the design uses these ticks instead of derived clocks. A start/pause/stop/clear state machine counts elapsed game seconds in BCD (000–999) for the scoreboard display.

## Interface
- CLK_HZ, 50000000, input clock frequency in Hz; must be a multiple of 10000 and ≥ 20000.
- CLK  in  1  system clock; all logic on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle command: begin a new game timing.
- PAUSE  in  1  one-cycle command: toggle between RUN and PAUSED.
- STOP  in  1  one-cycle command: freeze the count (game won or lost).
- CLR  in  1  one-cycle command: return to IDLE with count 0.
- TICK_10K, TICK_1K, TICK_100, TICK_1  out  1 each  registered one-cycle enable pulses.
- SEC_BCD  out  12  elapsed seconds, three BCD digits, [11:8] hundreds.
- STATE  out  2  0=IDLE, 1=RUN, 2=PAUSED, 3=DONE.
- RUNNING  out  1  high in RUN only.
- TIMER_MAX  out  1  high while SEC_BCD = 999 and STATE = DONE.

## Operation
- Prescaler: base counter 0..CLK_HZ/10000−1, width $clog2(CLK_HZ/10000). Its terminal count raises TICK_10K. Decade counters 0..9 then cascade: every 10th TICK_10K raises TICK_1K, every 10th TICK_1K raises TICK_100, every 10th TICK_100 raises TICK_1. Ticks that coincide assert in the same cycle.
- The prescaler free-runs in all states. START restarts the prescaler from zero, so the first TICK_1 after START occurs exactly CLK_HZ cycles later.
- Command priority when several are high in one cycle: CLR > STOP > START > PAUSE.
- IDLE: START → RUN with SEC_BCD cleared. PAUSE and STOP are ignored.
- RUN: TICK_1 increments SEC_BCD with BCD carry (x9 → (x+1)0, 099 → 100). At 999, TICK_1 holds the count at 999 and moves to DONE. STOP → DONE. PAUSE → PAUSED. START restarts the count at 000 and stays in RUN.
- PAUSED: TICK_1 is not counted. PAUSE → RUN. STOP → DONE. START → RUN with count 000. The sub-second prescaler phase is not preserved across a pause.
- DONE: the count is frozen. START → RUN with count 000.
- CLR in any state → IDLE with count 000.
- If a command that leaves RUN arrives in the same cycle as TICK_1, the command wins and that tick is not counted.

## Timing
- Reset values: all ticks 0, SEC_BCD 000, STATE IDLE, RUNNING 0, TIMER_MAX 0, all prescaler counters 0.
- Reset assertion clears everything immediately, independent of CLK. The first TICK_10K appears CLK_HZ/10000 cycles after reset is released.
- Each tick is high for exactly one CLK cycle. Tick periods are exactly CLK_HZ/10000, /1000, /100 and /1 cycles.
- A command sampled at edge n drives the new STATE, RUNNING and SEC_BCD values from edge n onward, i.e. one cycle of latency.
- A TICK_1 that is high in cycle n updates SEC_BCD at the following edge.

## Configuration
- TIMER_PAUSE_EN defined: PAUSE input and the PAUSED state behave as described above.
- TIMER_PAUSE_EN undefined: PAUSE is ignored, the PAUSED state is not built, and STATE never reads 2. The prescaler and all other behaviour are unchanged.

## Test plan
- Tick rates (CLK_HZ=20000): release reset → TICK_10K every 2 cycles, TICK_1K every 20, TICK_100 every 200, TICK_1 every 2000. TICK_1 coincides with the other three ticks.
- Count and carry: START, then run 100 TICK_1 pulses → SEC_BCD passes 009→010 and 099→100. The first increment occurs exactly 2000 cycles after START.
- Saturation: preset the count to 998 by running, then apply two TICK_1 pulses → SEC_BCD=999, STATE=DONE, TIMER_MAX=1. A further TICK_1 leaves SEC_BCD at 999.
- Pause/stop: START, 3 s, PAUSE for 5000 cycles → SEC_BCD stays 003. PAUSE again → counting resumes. STOP in the same cycle as TICK_1 → DONE with no increment.
- Priority and reset: assert CLR and START together in RUN → IDLE with count 000. Pull RST_N low mid-count → all outputs at reset values without waiting for a CLK edge.
- With TIMER_PAUSE_EN undefined: PAUSE in RUN → STATE remains 1 and counting continues.

Source files
------------

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: cascaded 10 kHz / 1 kHz / 100 Hz / 1 Hz enable-tick
// prescaler plus a start/pause/stop/clear game timer counting seconds in BCD.
// Optional feature macro: TIMER_PAUSE_EN builds the PAUSED state and makes
// i_pause toggle RUN <-> PAUSED. Without it i_pause is ignored.
module game_tick_scheduler #(
    parameter int CLK_HZ = 50000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_stop,
    input  logic        i_clr,
    output logic        o_tick_10k,
    output logic        o_tick_1k,
    output logic        o_tick_100,
    output logic        o_tick_1,
    output logic [11:0] o_sec_bcd,
    output logic [1:0]  o_state,
    output logic        o_running,
    output logic        o_timer_max
);

    localparam int DIV = CLK_HZ / 10000;
    localparam int BW  = $clog2(DIV);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    logic [BW-1:0] r_base;
    logic [3:0]    r_dec_1k;
    logic [3:0]    r_dec_100;
    logic [3:0]    r_dec_1;
    logic          r_tick_10k;
    logic          r_tick_1k;
    logic          r_tick_100;
    logic          r_tick_1;
    state_t        r_state;
    logic [11:0]   r_sec_bcd;
    logic          r_running;
    logic          r_timer_max;

    logic w_tc_10k;
    logic w_tc_1k;
    logic w_tc_100;
    logic w_tc_1;
    logic w_restart;

    // Terminal counts of each prescaler stage; a stage only advances on the
    // terminal count of the stage below, so coinciding ticks line up.
    assign w_tc_10k = (r_base == BW'(DIV - 1));
    assign w_tc_1k  = w_tc_10k && (r_dec_1k  == 4'd9);
    assign w_tc_100 = w_tc_1k  && (r_dec_100 == 4'd9);
    assign w_tc_1   = w_tc_100 && (r_dec_1   == 4'd9);

    // An accepted START re-phases the prescaler so the first second is full.
    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_restart = 1'b0;
        if (i_start && !i_clr) begin
            case (r_state)
                ST_RUN, ST_PAUSED: w_restart = !i_stop;
                default:           w_restart = 1'b1;
            endcase
        end
    end

    // BCD increment with carry across the three digits (x9 -> (x+1)0).
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] d0, d1, d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    // Free-running cascaded prescaler with registered single-cycle ticks.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base     <= '0;
            r_dec_1k   <= 4'd0;
            r_dec_100  <= 4'd0;
            r_dec_1    <= 4'd0;
            r_tick_10k <= 1'b0;
            r_tick_1k  <= 1'b0;
            r_tick_100 <= 1'b0;
            r_tick_1   <= 1'b0;
        end else if (w_restart) begin
            r_base     <= '0;
            r_dec_1k   <= 4'd0;
            r_dec_100  <= 4'd0;
            r_dec_1    <= 4'd0;
            r_tick_10k <= 1'b0;
            r_tick_1k  <= 1'b0;
            r_tick_100 <= 1'b0;
            r_tick_1   <= 1'b0;
        end else begin
            r_base <= w_tc_10k ? '0 : r_base + BW'(1);
            if (w_tc_10k) r_dec_1k  <= (r_dec_1k  == 4'd9) ? 4'd0 : r_dec_1k  + 4'd1;
            if (w_tc_1k)  r_dec_100 <= (r_dec_100 == 4'd9) ? 4'd0 : r_dec_100 + 4'd1;
            if (w_tc_100) r_dec_1   <= (r_dec_1   == 4'd9) ? 4'd0 : r_dec_1   + 4'd1;
            r_tick_10k <= w_tc_10k;
            r_tick_1k  <= w_tc_1k;
            r_tick_100 <= w_tc_100;
            r_tick_1   <= w_tc_1;
        end
    end

    // Game timer FSM: priority CLR > STOP > START > PAUSE > TICK_1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_sec_bcd   <= 12'h000;
            r_running   <= 1'b0;
            r_timer_max <= 1'b0;
        end else if (i_clr) begin
            r_state     <= ST_IDLE;
            r_sec_bcd   <= 12'h000;
            r_running   <= 1'b0;
            r_timer_max <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state   <= ST_RUN;
                        r_sec_bcd <= 12'h000;
                        r_running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_stop) begin
                        r_state     <= ST_DONE;
                        r_running   <= 1'b0;
                        r_timer_max <= (r_sec_bcd == 12'h999);
                    end else if (i_start) begin
                        r_sec_bcd <= 12'h000;
`ifdef TIMER_PAUSE_EN
                    end else if (i_pause) begin
                        r_state   <= ST_PAUSED;
                        r_running <= 1'b0;
`endif
                    end else if (r_tick_1) begin
                        if (r_sec_bcd == 12'h999) begin
                            r_state     <= ST_DONE;
                            r_running   <= 1'b0;
                            r_timer_max <= 1'b1;
                        end else begin
                            r_sec_bcd <= bcd_inc(r_sec_bcd);
                        end
                    end
                end
`ifdef TIMER_PAUSE_EN
                ST_PAUSED: begin
                    if (i_stop) begin
                        r_state     <= ST_DONE;
                        r_timer_max <= (r_sec_bcd == 12'h999);
                    end else if (i_start) begin
                        r_state   <= ST_RUN;
                        r_sec_bcd <= 12'h000;
                        r_running <= 1'b1;
                    end else if (i_pause) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    if (i_start) begin
                        r_state     <= ST_RUN;
                        r_sec_bcd   <= 12'h000;
                        r_running   <= 1'b1;
                        r_timer_max <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_sec_bcd   <= 12'h000;
                    r_running   <= 1'b0;
                    r_timer_max <= 1'b0;
                end
            endcase
        end
    end

    assign o_tick_10k  = r_tick_10k;
    assign o_tick_1k   = r_tick_1k;
    assign o_tick_100  = r_tick_100;
    assign o_tick_1    = r_tick_1;
    assign o_sec_bcd   = r_sec_bcd;
    assign o_state     = r_state;
    assign o_running   = r_running;
    assign o_timer_max = r_timer_max;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed testbench for game_tick_scheduler at CLK_HZ = 20000
// (TICK_10K every 2 cycles, TICK_1 every 2000 cycles).
module tb_game_tick_scheduler;

    localparam int CLK_HZ = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        stop = 1'b0;
    logic        clr = 1'b0;
    logic        tick_10k, tick_1k, tick_100, tick_1;
    logic [11:0] sec_bcd;
    logic [1:0]  state;
    logic        running, timer_max;
    logic [11:0] preset_val;

    int checks = 0;
    int errors = 0;

    game_tick_scheduler #(.CLK_HZ(CLK_HZ)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_pause    (pause),
        .i_stop     (stop),
        .i_clr      (clr),
        .o_tick_10k (tick_10k),
        .o_tick_1k  (tick_1k),
        .o_tick_100 (tick_100),
        .o_tick_1   (tick_1),
        .o_sec_bcd  (sec_bcd),
        .o_state    (state),
        .o_running  (running),
        .o_timer_max(timer_max)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle command set, sampled by the next rising edge.
    task automatic cmd(input logic s, input logic p, input logic t, input logic c);
        @(negedge clk);
        start = s; pause = p; stop = t; clr = c;
        step();
        start = 1'b0; pause = 1'b0; stop = 1'b0; clr = 1'b0;
    endtask

    // Load the seconds register to shorten long count sequences.
    task automatic preset(input logic [11:0] v);
        @(negedge clk);
        preset_val = v;
        force dut.r_sec_bcd = preset_val;
        #1;
        release dut.r_sec_bcd;
    endtask

    // Step until TICK_1 is seen (bounded); n = edges taken.
    task automatic wait_tick1(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_1 && n < 5000);
        checks++;
        if (tick_1 !== 1'b1) begin
            errors++;
            $display("FAIL tick1_timeout: got tick_1=%b after %0d cycles, required 1", tick_1, n);
        end
    endtask

    // Wait for TICK_1 and the edge that counts it.
    task automatic next_second();
        int n;
        wait_tick1(n);
        step();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({tick_10k, tick_1k, tick_100, tick_1} !== 4'b0000) begin
            errors++; $display("FAIL reset_ticks: got %b required 0000", {tick_10k, tick_1k, tick_100, tick_1});
        end
        checks++;
        if ({sec_bcd, state, running, timer_max} !== 16'h0000) begin
            errors++; $display("FAIL reset_outputs: got sec=%h state=%0d run=%b max=%b required 000/0/0/0",
                               sec_bcd, state, running, timer_max);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_tick_rates();
        int n10k = 0, n1k = 0, n100 = 0, n1 = 0;
        int f10k = 0, f1k = 0, f100 = 0, f1 = 0;
        logic coincide = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 4000; e++) begin
            step();
            if (tick_10k) begin n10k++; if (f10k == 0) f10k = e; end
            if (tick_1k)  begin n1k++;  if (f1k  == 0) f1k  = e; end
            if (tick_100) begin n100++; if (f100 == 0) f100 = e; end
            if (tick_1)   begin n1++;   if (f1   == 0) f1   = e; end
            if (e == 2000) coincide = tick_10k & tick_1k & tick_100 & tick_1;
        end
        checks++;
        if (f10k !== 2 || f1k !== 20 || f100 !== 200 || f1 !== 2000) begin
            errors++; $display("FAIL tick_first: got %0d/%0d/%0d/%0d required 2/20/200/2000", f10k, f1k, f100, f1);
        end
        checks++;
        if (n10k !== 2000 || n1k !== 200 || n100 !== 20 || n1 !== 2) begin
            errors++; $display("FAIL tick_counts: got %0d/%0d/%0d/%0d required 2000/200/20/2", n10k, n1k, n100, n1);
        end
        checks++;
        if (coincide !== 1'b1) begin
            errors++; $display("FAIL tick_coincide: got %b required 1", coincide);
        end
    endtask

    task automatic test_idle_ignore();
        cmd(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (state !== 2'd0 || running !== 1'b0) begin
            errors++; $display("FAIL idle_ignore: got state=%0d run=%b required 0/0", state, running);
        end
    endtask

    task automatic test_count_carry();
        int n;
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd1 || running !== 1'b1 || sec_bcd !== 12'h000) begin
            errors++; $display("FAIL start_run: got state=%0d run=%b sec=%h required 1/1/000", state, running, sec_bcd);
        end
        wait_tick1(n);
        checks++;
        if (n !== 2000) begin
            errors++; $display("FAIL first_tick1_latency: got %0d required 2000", n);
        end
        checks++;
        if (sec_bcd !== 12'h000) begin
            errors++; $display("FAIL pre_increment: got %h required 000", sec_bcd);
        end
        step();
        checks++;
        if (sec_bcd !== 12'h001) begin
            errors++; $display("FAIL first_increment: got %h required 001", sec_bcd);
        end
        preset(12'h008);
        next_second();
        checks++;
        if (sec_bcd !== 12'h009) begin errors++; $display("FAIL count_009: got %h required 009", sec_bcd); end
        next_second();
        checks++;
        if (sec_bcd !== 12'h010) begin errors++; $display("FAIL carry_010: got %h required 010", sec_bcd); end
        preset(12'h098);
        next_second();
        checks++;
        if (sec_bcd !== 12'h099) begin errors++; $display("FAIL count_099: got %h required 099", sec_bcd); end
        next_second();
        checks++;
        if (sec_bcd !== 12'h100) begin errors++; $display("FAIL carry_100: got %h required 100", sec_bcd); end
        preset(12'h199);
        next_second();
        checks++;
        if (sec_bcd !== 12'h200) begin errors++; $display("FAIL carry_200: got %h required 200", sec_bcd); end
    endtask

    task automatic test_saturation();
        preset(12'h998);
        next_second();
        checks++;
        if (sec_bcd !== 12'h999 || state !== 2'd1 || timer_max !== 1'b0) begin
            errors++; $display("FAIL sat_999_run: got sec=%h state=%0d max=%b required 999/1/0", sec_bcd, state, timer_max);
        end
        next_second();
        checks++;
        if (sec_bcd !== 12'h999 || state !== 2'd3 || timer_max !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL sat_done: got sec=%h state=%0d max=%b run=%b required 999/3/1/0",
                               sec_bcd, state, timer_max, running);
        end
        next_second();
        checks++;
        if (sec_bcd !== 12'h999 || state !== 2'd3) begin
            errors++; $display("FAIL sat_hold: got sec=%h state=%0d required 999/3", sec_bcd, state);
        end
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd1 || sec_bcd !== 12'h000 || timer_max !== 1'b0) begin
            errors++; $display("FAIL done_restart: got state=%0d sec=%h max=%b required 1/000/0", state, sec_bcd, timer_max);
        end
    endtask

    task automatic test_pause_stop();
        int n;
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) next_second();
        checks++;
        if (sec_bcd !== 12'h003) begin errors++; $display("FAIL run_3s: got %h required 003", sec_bcd); end
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef TIMER_PAUSE_EN
        checks++;
        if (state !== 2'd2 || running !== 1'b0) begin
            errors++; $display("FAIL pause_enter: got state=%0d run=%b required 2/0", state, running);
        end
        repeat (5000) step();
        checks++;
        if (sec_bcd !== 12'h003 || state !== 2'd2) begin
            errors++; $display("FAIL pause_hold: got sec=%h state=%0d required 003/2", sec_bcd, state);
        end
        cmd(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd1 || running !== 1'b1) begin
            errors++; $display("FAIL pause_resume: got state=%0d run=%b required 1/1", state, running);
        end
`else
        checks++;
        if (state !== 2'd1 || running !== 1'b1) begin
            errors++; $display("FAIL pause_ignored: got state=%0d run=%b required 1/1", state, running);
        end
`endif
        next_second();
        checks++;
        if (sec_bcd !== 12'h004) begin errors++; $display("FAIL count_after_pause: got %h required 004", sec_bcd); end
        wait_tick1(n);
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (state !== 2'd3 || sec_bcd !== 12'h004 || timer_max !== 1'b0) begin
            errors++; $display("FAIL stop_on_tick: got state=%0d sec=%h max=%b required 3/004/0", state, sec_bcd, timer_max);
        end
    endtask

    task automatic test_priority();
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        next_second();
        cmd(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (state !== 2'd0 || sec_bcd !== 12'h000 || running !== 1'b0) begin
            errors++; $display("FAIL clr_over_start: got state=%0d sec=%h run=%b required 0/000/0", state, sec_bcd, running);
        end
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        cmd(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (state !== 2'd3 || running !== 1'b0) begin
            errors++; $display("FAIL stop_over_start: got state=%0d run=%b required 3/0", state, running);
        end
        cmd(1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL clr_over_all: got state=%0d required 0", state); end
    endtask

    task automatic test_async_reset();
        int n;
        cmd(1'b1, 1'b0, 1'b0, 1'b0);
        next_second();
        n = 0;
        while (!tick_10k && n < 4) begin step(); n++; end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tick_10k, tick_1k, tick_100, tick_1, sec_bcd, state, running, timer_max} !== 20'h0) begin
            errors++; $display("FAIL async_reset: got ticks=%b sec=%h state=%0d run=%b max=%b required all 0",
                               {tick_10k, tick_1k, tick_100, tick_1}, sec_bcd, state, running, timer_max);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin step(); n++; end while (!tick_10k && n < 10);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL first_10k_after_reset: got %0d required 2", n); end
    endtask

    initial begin
        test_reset();
        test_tick_rates();
        test_idle_ignore();
        test_count_carry();
        test_saturation();
        test_pause_stop();
        test_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
